// File: rtl/vp_pkg.sv
// Shared definitions for the DVP ROI processing stage: mode encodings,
// BT.601-style luma weights and RGB565 constants.
package vp_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_CROP   = 2'b01,
      MODE_BIN    = 2'b10,
      MODE_HILITE = 2'b11
   } vp_mode_e;

   // Luma weights scaled by 256; they sum to 256 so Y8 never exceeds 255.
   localparam logic [15:0] LUMA_R = 16'd77;
   localparam logic [15:0] LUMA_G = 16'd150;
   localparam logic [15:0] LUMA_B = 16'd29;

   localparam logic [15:0] WHITE565 = 16'hFFFF;
   localparam logic [15:0] BLACK565 = 16'h0000;

   // Halve each RGB565 channel independently (shift right, drop the lsb).
   function automatic logic [15:0] halve565(input logic [15:0] p);
      return {1'b0, p[15:12], 1'b0, p[10:6], 1'b0, p[4:1]};
   endfunction

endpackage

// File: rtl/vp_luma565.sv
// Registered RGB565 to 8-bit luma converter, one cycle of latency.
module vp_luma565
   import vp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pix,
   output logic [7:0]  luma
);

   logic [7:0]  r8;
   logic [7:0]  g8;
   logic [7:0]  b8;
   logic [15:0] acc;

   // Expand channels to 8 bits by msb replication, then weighted sum.
   always_comb begin
      r8  = {pix[15:11], pix[15:13]};
      g8  = {pix[10:5], pix[10:9]};
      b8  = {pix[4:0], pix[4:2]};
      acc = LUMA_R * {8'd0, r8} + LUMA_G * {8'd0, g8} + LUMA_B * {8'd0, b8};
   end

   // Luma output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         luma <= 8'd0;
      end else begin
         luma <= acc[15:8];
      end
   end

endmodule

// File: rtl/vp_roi_proc.sv
// Frame-level ROI processing: crop, binarize or highlight a window of the
// incoming RGB565 stream. Settings are shadowed on the vsync rising edge so
// a frame is always processed with one consistent configuration.
module vp_roi_proc
   import vp_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned X_W        = 11,
   parameter int unsigned Y_W        = 11,
   parameter logic [7:0]  BIN_TH_DEF = 8'h80
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cfg_mode,
   input  logic [X_W-1:0]    cfg_start_x,
   input  logic [Y_W-1:0]    cfg_start_y,
   input  logic [X_W-1:0]    cfg_end_x,
   input  logic [Y_W-1:0]    cfg_end_y,
   input  logic [7:0]        cfg_th,
   input  logic              pre_vs,
   input  logic              pre_de,
   input  logic [DATA_W-1:0] pre_data,
   output logic              post_vs,
   output logic              post_de,
   output logic [DATA_W-1:0] post_data,
   output logic              frame_start,
   output logic              cfg_err
);

   // Frame control state
   logic           vs_d;
   logic           de_d;
   logic           armed;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;

   // Shadowed configuration
   vp_mode_e       mode_sh;
   logic [X_W-1:0] sx;
   logic [Y_W-1:0] sy;
   logic [X_W-1:0] ex;
   logic [Y_W-1:0] ey;
   logic [7:0]     th_sh;

   // Stage 1
   logic              s1_vs;
   logic              s1_de;
   logic              s1_inwin;
   logic [DATA_W-1:0] s1_pix;
   vp_mode_e          s1_mode;
   logic [7:0]        s1_th;
   logic [7:0]        s1_luma;

   // Stage 2 next-state and frame_start edge detect
   logic              de_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              post_vs_d;

   logic vs_rise;
   logic de_fall;
   logic inwin;

   // Edge detects and window membership for the current pixel position.
   always_comb begin
      vs_rise = pre_vs & ~vs_d;
      de_fall = ~pre_de & de_d;
      inwin   = (x >= sx) & (x < ex) & (y >= sy) & (y < ey);
   end

   // Configuration shadowing and saturating pixel/line counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d    <= 1'b0;
         de_d    <= 1'b0;
         armed   <= 1'b0;
         x       <= '0;
         y       <= '0;
         mode_sh <= MODE_BYPASS;
         sx      <= '0;
         sy      <= '0;
         ex      <= '1;
         ey      <= '1;
         th_sh   <= BIN_TH_DEF;
         cfg_err <= 1'b0;
      end else begin
         vs_d <= pre_vs;
         de_d <= pre_de;
         if (vs_rise) begin
            mode_sh <= vp_mode_e'(cfg_mode);
            sx      <= cfg_start_x;
            sy      <= cfg_start_y;
            ex      <= cfg_end_x;
            ey      <= cfg_end_y;
            th_sh   <= cfg_th;
            cfg_err <= (cfg_end_x <= cfg_start_x) | (cfg_end_y <= cfg_start_y);
            armed   <= 1'b1;
            x       <= '0;
            y       <= '0;
         end else if (pre_de) begin
            if (x != '1) begin
               x <= x + X_W'(1);
            end
         end else if (de_fall) begin
            x <= '0;
            if (y != '1) begin
               y <= y + Y_W'(1);
            end
         end
      end
   end

   // Luma is computed in parallel with stage 1 so it lines up with s1_*.
   vp_luma565 u_luma (
      .clk  (clk),
      .rst  (rst),
      .pix  (pre_data),
      .luma (s1_luma)
   );

   // Stage 1: capture pixel, timing and the effective mode for this pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vs    <= 1'b0;
         s1_de    <= 1'b0;
         s1_inwin <= 1'b0;
         s1_pix   <= '0;
         s1_mode  <= MODE_BYPASS;
         s1_th    <= BIN_TH_DEF;
      end else begin
         s1_vs    <= pre_vs;
         s1_de    <= pre_de & armed;
         s1_inwin <= inwin;
         s1_pix   <= pre_data;
         s1_mode  <= cfg_err ? MODE_BYPASS : mode_sh;
         s1_th    <= th_sh;
      end
   end

   // Stage 2 mode select.
   always_comb begin
      de_nxt   = s1_de;
      data_nxt = s1_pix;
      case (s1_mode)
         MODE_CROP: begin
            de_nxt   = s1_de & s1_inwin;
            data_nxt = (s1_de & s1_inwin) ? s1_pix : BLACK565;
         end
         MODE_BIN: begin
            de_nxt   = s1_de & s1_inwin;
            data_nxt = (s1_luma >= s1_th) ? WHITE565 : BLACK565;
         end
         MODE_HILITE: begin
            data_nxt = s1_inwin ? s1_pix : halve565(s1_pix);
         end
         default: begin
            de_nxt   = s1_de;
            data_nxt = s1_pix;
         end
      endcase
   end

   // Stage 2 output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         post_vs   <= 1'b0;
         post_de   <= 1'b0;
         post_data <= '0;
         post_vs_d <= 1'b0;
      end else begin
         post_vs   <= s1_vs;
         post_de   <= de_nxt;
         post_data <= data_nxt;
         post_vs_d <= post_vs;
      end
   end

   assign frame_start = post_vs & ~post_vs_d;

endmodule

// File: doc/vp_roi_proc.md
Name: vp_roi_proc

Overview:
- Runtime-configurable frame-processing stage for the DVP video path: crop window, highlight window, and luma binarization, all selected by a mode field.
- Mode and window settings are software-programmed and are shadowed at frame start, so a frame is never processed with mixed settings.
- Sits between the RGB565 video input and the filler/output stage in the pixel clock domain.
- Single clock, fixed 2-cycle pipeline latency.

Parameters:
- DATA_W, 16, pixel width; RGB565 packing {R5,G6,B5}. Only 16 is supported.
- X_W, 11, width of the column counter and window X coordinates.
- Y_W, 11, width of the line counter and window Y coordinates.
- BIN_TH_DEF, 8'h80, binarize threshold loaded by reset.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- cfg_mode  in  2  00 bypass, 01 crop, 10 crop+binarize, 11 highlight
- cfg_start_x  in  X_W  window first column (inclusive)
- cfg_start_y  in  Y_W  window first line (inclusive)
- cfg_end_x  in  X_W  window end column (exclusive)
- cfg_end_y  in  Y_W  window end line (exclusive)
- cfg_th  in  8  binarize luma threshold
- pre_vs  in  1  input vsync, active-high pulse at frame start
- pre_de  in  1  input data enable
- pre_data  in  DATA_W  input pixel
- post_vs  out  1  output vsync
- post_de  out  1  output data enable
- post_data  out  DATA_W  output pixel
- frame_start  out  1  one-cycle pulse, aligned with the first post_vs cycle
- cfg_err  out  1  window of the current frame is invalid

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs 0.
  - Shadow state loaded: mode=00, window=(0,0)-(all-ones, all-ones), th=BIN_TH_DEF.
  - x=0, y=0, armed=0.
- Armed gate: post_de stays 0 until the first pre_vs rising edge after reset. This discards a partial frame.
- Shadowing, on a pre_vs rising edge (pre_vs=1, vs_d=0):
  - All cfg_* inputs are captured into the shadow registers.
  - y=0, armed=1.
  - cfg_err = (end_x<=start_x) | (end_y<=start_y).
  - cfg changes at any other time have no effect until the next frame.
- Invalid window: when cfg_err=1, the frame is processed as mode 00 (bypass). cfg_err holds until the next frame start.
- Counters:
  - x increments on each pre_de=1 cycle and resets to 0 on a pre_de falling edge.
  - y increments on each pre_de falling edge.
  - Both saturate at all-ones; no wrap.
- inwin = (x>=sx)&(x<ex)&(y>=sy)&(y<ey), evaluated on the current x,y before they increment.
- Stage 1 (registered):
  - Pixel expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - Y8=(77*R8+150*G8+29*B8)>>8, using a 16-bit accumulator (max 65280, no overflow).
  - Register inwin, de, vs, and the raw pixel.
- Stage 2 (registered output):
  - 00: post_data=pixel; post_de=de.
  - 01: post_de=de&inwin; post_data=pixel when post_de=1, else 0.
  - 10: post_de=de&inwin; post_data=16'hFFFF if Y8>=th, else 16'h0000.
  - 11: post_de=de.
    - Inside the window: pixel.
    - Outside the window: each channel halved, i.e. {0,R5[4:1],0,G6[5:1],0,B5[4:1]}.
- Latency: post_vs, post_de and post_data lag the inputs by exactly 2 clk cycles in every mode.
- frame_start = post_vs & ~post_vs_d.
- Reset mid-frame: everything returns to the reset state within 1 cycle. Output resumes only at the next pre_vs rising edge.
- pre_de during pre_vs=1: passed through normally; the counters are already cleared.

Decomposition:
- Shared package vp_pkg:
  - Mode encodings MODE_BYPASS/CROP/BIN/HILITE.
  - Luma coefficients 77/150/29.
  - WHITE565=16'hFFFF, BLACK565=16'h0000.
- One sub-module, vp_luma565: registered RGB565→Y8 converter, 1-cycle latency.

Test Plan:
1. Reset, then a 4x3 frame in mode 00 with pixels 16'h1234..: post_data equals the input delayed 2 cycles; 12 de cycles; frame_start asserted once.
2. Mode 01, window (1,1)-(3,2), 4x3 frame: exactly 2 post_de cycles, carrying the pixels at (1,1) and (2,1).
3. Mode 10, th=8'h80, pixels F800 (Y=76), FFFF (Y=255), 07E0 (Y=149): outputs 0000, FFFF, FFFF.
4. Mode 11, window (0,0)-(1,1), pixel FFFF at (1,0): output 7BEF; at (0,0): output FFFF.
5. cfg_mode changed mid-frame from 00 to 01: current frame stays bypass; next frame is cropped.
6. Window end_x=start_x=5: cfg_err=1 and the frame is bypassed. Separately, rst pulsed mid-line: outputs 0; post_de stays 0 until the next pre_vs rising edge.
